mem_line_responder: RTL
=======================

# mem_line_responder

Memory-side responder for the data cache's line-transfer interface. It accepts 128-bit line read, write and write-then-read requests (`mem_read`/`mem_write`/`mem_addr`/`mem_mask`) and serializes each line as 16 byte transfers to a byte-wide synchronous RAM. It reports progress back with `mem_busy` and `mem_done`. It sits between the data cache and the board memory.

## Interface
- `ADDR_W`, 32, address width.
- `LINE_BYTES`, 16, bytes per line. Only 16 is supported; the value matches the 128-bit line width and `mem_mask` width.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset; **asynchronous, active-low**.
- `mem_read`  in  1  read-line request from the cache.
- `mem_write`  in  1  write-line request from the cache.
- `mem_addr`  in  32  request address; bits [3:0] are ignored, so the line base is {addr[31:4],4'b0}.
- `mem_wdata`  in  128  write line; byte i is bits [8i+7:8i].
- `mem_mask`  in  16  byte enables; bit i enables byte i.
- `mem_rdata`  out  128  read line; holds its value until the next read completes.
- `mem_busy`  out  1  request in progress.
- `mem_done`  out  1  one-cycle completion pulse.
- `ram_addr`  out  32  byte address to the RAM.
- `ram_we`  out  1  RAM byte write enable.
- `ram_wdata`  out  8  RAM write byte.
- `ram_rdata`  in  8  RAM read byte; valid one cycle after `ram_addr` is presented with `ram_we`=0.

## Operation
- States: IDLE, WRITE, READ, DONE. A 5-bit counter `cnt` is shared by WRITE and READ.
- **IDLE**
  - Samples the request inputs.
  - If `mem_write` is high: latch the line base, `mem_wdata` and `mem_mask`; latch `pend_rd`=`mem_read`; go to WRITE with cnt=0.
  - Else if `mem_read` is high: latch the line base; go to READ with cnt=0.
  - Otherwise stay in IDLE.
- **WRITE** (cnt 0..15)
  - `ram_addr`=base+cnt, `ram_wdata`=byte cnt, `ram_we`=mask[cnt].
  - Bytes with a mask bit of 0 still take their cycle, with `ram_we`=0.
  - At cnt=15: if `pend_rd`, go to READ with cnt=0; otherwise go to DONE.
- **READ** (cnt 0..16)
  - For cnt<16: `ram_addr`=base+cnt, `ram_we`=0.
  - For cnt≥1: capture `ram_rdata` into byte cnt-1 of the assembly buffer.
  - At cnt=16: go to DONE.
- **DONE**
  - `mem_done`=1 for exactly one cycle.
  - If a read was performed, `mem_rdata` takes the assembled line on the DONE entry edge.
  - Request inputs are ignored in this state. Next state is IDLE.
- `mem_busy`=1 in WRITE, READ and DONE; 0 in IDLE.
- Simultaneous read and write: the write phase always completes before the read phase, at the same line base. A single `mem_done` is issued, at the end.
- Requester rule: the requester deasserts its request in the cycle it sees `mem_done`. A request still high in the following IDLE cycle is accepted as a new request.
- Address arithmetic: base+cnt with cnt<16 never carries past bit 3, so there is no line wrap.

## Timing
- Reset values (applied asynchronously while `RST`=0):
  - State IDLE, cnt 0.
  - `mem_busy`=0, `mem_done`=0, `mem_rdata`=0.
  - `ram_addr`=0, `ram_we`=0, `ram_wdata`=0.
- Reset mid-transfer: the transfer aborts immediately, `ram_we` drops without waiting for a clock, no `mem_done` is issued and the partial read line is discarded.
- All outputs are registers or are decoded from registered state; there are no combinational paths from inputs to outputs.
- Latency, with request sampled at edge 0:
  - Read only: READ during cycles 1–17, `mem_done` in cycle 18.
  - Write only: WRITE during cycles 1–16, `mem_done` in cycle 17.
  - Write plus read: WRITE 1–16, READ 17–33, `mem_done` in cycle 34.
- RAM read latency is fixed at 1 cycle. Byte k is captured at the end of READ cycle cnt=k+1.

## Structure
- Shared `config.vh` carries:
  - `ADDR_WIDTH` and `BENCH_WIDTH` (127:0);
  - a line-bytes constant (16) and the mask width (16);
  - the responder state encodings (IDLE=2'd0, WRITE=2'd1, READ=2'd2, DONE=2'd3).
- One sub-module is natural: `mem_line_buffer`, a 128-bit assembly register with a byte-indexed write port (4-bit index, 8-bit data, enable) and a parallel 128-bit output. It is instantiated for read assembly.

## Test plan
- **Reset:** hold `RST`=0 mid-READ (cnt=7) → all outputs 0 asynchronously; after release, idle with `mem_busy`=0 and no `mem_done`.
- **Read only:** RAM preloaded with bytes 0x00..0x0F at 0x1000..0x100F; `mem_read`=1, `mem_addr`=0x1004 → `ram_addr` steps 0x1000..0x100F; `mem_done` in cycle 18; `mem_rdata`=0x0F0E…0100.
- **Masked write:** `mem_write`=1, `mem_addr`=0x2000, `mem_wdata`=0xAABB…, `mem_mask`=16'h000F → exactly 4 `ram_we` pulses (addresses 0x2000..0x2003); other bytes unchanged; `mem_done` in cycle 17.
- **Write plus read:** `mem_write`=`mem_read`=1, `mem_mask`=16'hFFFF, `mem_addr`=0x3000 → 16 writes, then 16 reads return the written line; `mem_done` in cycle 34 only.
- **Back-to-back:** `mem_read` held high one cycle past `mem_done` → second read accepted in the following IDLE cycle; `mem_busy` low for exactly that one IDLE cycle.

Source files
------------

// File: rtl/mem_line_responder_pkg.sv
// Shared constants, state encoding and byte helper for the cache line responder.
package mem_line_responder_pkg;

    localparam int ADDR_WIDTH   = 32;
    localparam int BENCH_WIDTH  = 128;
    localparam int LINE_BYTES_C = 16;
    localparam int MASK_WIDTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } resp_state_e;

    function automatic logic [7:0] line_byte(input logic [BENCH_WIDTH-1:0] line,
                                             input logic [3:0] idx);
        return line[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_line_responder_buffer.sv
// 128-bit line assembly register with a byte-indexed write port.
module mem_line_responder_buffer
    import mem_line_responder_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   wr_en,
    input  logic [3:0]             wr_idx,
    input  logic [7:0]             wr_data,
    output logic [BENCH_WIDTH-1:0] line
);

    logic [BENCH_WIDTH-1:0] line_r;

    // Byte write into the assembly line; cleared by reset so aborted reads leave nothing behind
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            line_r <= {BENCH_WIDTH{1'b0}};
        end else if (wr_en) begin
            line_r[{wr_idx, 3'b000} +: 8] <= wr_data;
        end else begin
            line_r <= line_r;
        end
    end

    assign line = line_r;

endmodule

// File: rtl/mem_line_responder.sv
// Serializes 128-bit cache line read/write requests into 16 byte-wide RAM transfers.
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int ADDR_W     = ADDR_WIDTH,
    parameter int LINE_BYTES = LINE_BYTES_C
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [LINE_BYTES*8-1:0] mem_wdata,
    input  logic [LINE_BYTES-1:0]   mem_mask,
    output logic [LINE_BYTES*8-1:0] mem_rdata,
    output logic                    mem_busy,
    output logic                    mem_done,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic                    ram_we,
    output logic [7:0]              ram_wdata,
    input  logic [7:0]              ram_rdata
);

    localparam int LINE_W = LINE_BYTES * 8;

    resp_state_e            state_r;
    logic [4:0]             cnt_r;
    logic [ADDR_W-5:0]      base_r;
    logic [LINE_W-1:0]      wdata_r;
    logic [LINE_BYTES-1:0]  mask_r;
    logic                   pend_rd_r;
    logic [LINE_W-1:0]      mem_rdata_r;
    logic                   mem_busy_r;
    logic                   mem_done_r;
    logic [ADDR_W-1:0]      ram_addr_r;
    logic                   ram_we_r;
    logic [7:0]             ram_wdata_r;

    logic [3:0]             nxt_idx_s;
    logic                   buf_we_s;
    logic [3:0]             buf_idx_s;
    logic [LINE_W-1:0]      line_s;
    logic [LINE_W-1:0]      assembled_s;
    logic                   unused_lsb_s;

    assign nxt_idx_s    = cnt_r[3:0] + 4'd1;
    assign unused_lsb_s = ^mem_addr[3:0];
    // The last byte arrives on the same edge that publishes the line, so bypass the buffer for it
    assign assembled_s  = {ram_rdata, line_s[LINE_W-9:0]};

    // Read capture: RAM data lags the address by one cycle, so cnt k stores byte k-1
    always_comb begin
        buf_we_s  = 1'b0;
        buf_idx_s = cnt_r[3:0] - 4'd1;
        if ((state_r == ST_READ) && (cnt_r != 5'd0)) begin
            buf_we_s = 1'b1;
        end else begin
            buf_we_s = 1'b0;
        end
    end

    mem_line_responder_buffer u_buf (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (buf_we_s),
        .wr_idx  (buf_idx_s),
        .wr_data (ram_rdata),
        .line    (line_s)
    );

    // Responder FSM; RAM signals are registered one cycle ahead of the cnt they belong to
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 5'd0;
            base_r      <= {(ADDR_W-4){1'b0}};
            wdata_r     <= {LINE_W{1'b0}};
            mask_r      <= {LINE_BYTES{1'b0}};
            pend_rd_r   <= 1'b0;
            mem_rdata_r <= {LINE_W{1'b0}};
            mem_busy_r  <= 1'b0;
            mem_done_r  <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_we_r    <= 1'b0;
            ram_wdata_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_write) begin
                        base_r      <= mem_addr[ADDR_W-1:4];
                        wdata_r     <= mem_wdata;
                        mask_r      <= mem_mask;
                        pend_rd_r   <= mem_read;
                        state_r     <= ST_WRITE;
                        cnt_r       <= 5'd0;
                        mem_busy_r  <= 1'b1;
                        ram_addr_r  <= {mem_addr[ADDR_W-1:4], 4'd0};
                        ram_we_r    <= mem_mask[0];
                        ram_wdata_r <= mem_wdata[7:0];
                    end else if (mem_read) begin
                        base_r      <= mem_addr[ADDR_W-1:4];
                        pend_rd_r   <= 1'b0;
                        state_r     <= ST_READ;
                        cnt_r       <= 5'd0;
                        mem_busy_r  <= 1'b1;
                        ram_addr_r  <= {mem_addr[ADDR_W-1:4], 4'd0};
                        ram_we_r    <= 1'b0;
                    end else begin
                        mem_busy_r  <= 1'b0;
                        mem_done_r  <= 1'b0;
                        ram_we_r    <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (cnt_r == 5'd15) begin
                        ram_we_r <= 1'b0;
                        cnt_r    <= 5'd0;
                        if (pend_rd_r) begin
                            state_r    <= ST_READ;
                            ram_addr_r <= {base_r, 4'd0};
                        end else begin
                            state_r    <= ST_DONE;
                            mem_done_r <= 1'b1;
                        end
                    end else begin
                        cnt_r       <= cnt_r + 5'd1;
                        ram_addr_r  <= {base_r, nxt_idx_s};
                        ram_we_r    <= mask_r[nxt_idx_s];
                        ram_wdata_r <= line_byte(wdata_r, nxt_idx_s);
                    end
                end
                ST_READ: begin
                    if (cnt_r == 5'd16) begin
                        state_r     <= ST_DONE;
                        mem_done_r  <= 1'b1;
                        mem_rdata_r <= assembled_s;
                        cnt_r       <= 5'd0;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                        if (cnt_r != 5'd15) begin
                            ram_addr_r <= {base_r, nxt_idx_s};
                        end else begin
                            ram_addr_r <= ram_addr_r;
                        end
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    mem_done_r <= 1'b0;
                    mem_busy_r <= 1'b0;
                    cnt_r      <= 5'd0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= 5'd0;
                    mem_done_r <= 1'b0;
                    mem_busy_r <= 1'b0;
                    ram_we_r   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rdata = mem_rdata_r;
    assign mem_busy  = mem_busy_r;
    assign mem_done  = mem_done_r;
    assign ram_addr  = ram_addr_r;
    assign ram_we    = ram_we_r;
    assign ram_wdata = ram_wdata_r;

endmodule
